// File: rtl/commit_stage_mp_if.sv
// Instruction-window bus between the scoreboard (master) and the commit stage (slave).
// Port 0 is the oldest entry; an entry retires in the cycle its commit_ack_o bit is high, and acks always form a contiguous prefix.
interface commit_stage_mp_if #(
    parameter int unsigned N = 2
);
    logic [N-1:0]      instr_valid_i;
    logic [N-1:0]      instr_ex_i;
    logic [N-1:0][2:0] instr_kind_i;
    logic [N-1:0][4:0] instr_fflags_i;
    logic [N-1:0]      instr_rd_fpr_i;
    logic [N-1:0]      commit_ack_o;
    logic [N-1:0]      we_gpr_o;
    logic [N-1:0]      we_fpr_o;

    modport master (
        output instr_valid_i, instr_ex_i, instr_kind_i, instr_fflags_i, instr_rd_fpr_i,
        input  commit_ack_o, we_gpr_o, we_fpr_o
    );

    modport slave (
        input  instr_valid_i, instr_ex_i, instr_kind_i, instr_fflags_i, instr_rd_fpr_i,
        output commit_ack_o, we_gpr_o, we_fpr_o
    );
endinterface

// File: rtl/commit_stage_mp.sv
// Multi-port in-order commit stage: retires a prefix of the window each cycle and
// serialises fences and AMOs at port 0 through a small FSM; also keeps instret and a stall watchdog.
module commit_stage_mp #(
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter int unsigned CNT_WIDTH       = 64,
    parameter int unsigned WDOG_LIMIT      = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    commit_stage_mp_if.slave     instr_if,
    input  logic                 halt_i,
    input  logic                 single_step_i,
    input  logic                 commit_lsu_ready_i,
    input  logic                 no_st_pending_i,
    input  logic                 flush_ack_i,
    input  logic                 amo_ack_i,
    input  logic                 csr_exception_i,
    input  logic                 instret_inhibit_i,
    output logic                 commit_lsu_o,
    output logic                 commit_csr_o,
    output logic                 fence_o,
    output logic                 fence_i_o,
    output logic                 sfence_vma_o,
    output logic                 amo_valid_commit_o,
    output logic                 flush_commit_o,
    output logic                 csr_write_fflags_o,
    output logic [4:0]           fflags_o,
    output logic                 exception_valid_o,
    output logic [CNT_WIDTH-1:0] instret_o,
    output logic                 stall_timeout_o,
    output logic [1:0]           state_o
);

    localparam logic [2:0] K_SIMPLE  = 3'd0;
    localparam logic [2:0] K_STORE   = 3'd1;
    localparam logic [2:0] K_CSR     = 3'd2;
    localparam logic [2:0] K_FENCE   = 3'd3;
    localparam logic [2:0] K_FENCE_I = 3'd4;
    localparam logic [2:0] K_SFENCE  = 3'd5;
    localparam logic [2:0] K_AMO     = 3'd6;
    localparam logic [2:0] K_FPU     = 3'd7;
    localparam logic [15:0] WDOG_MAX = 16'(WDOG_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DRAIN    = 2'd1,
        S_FLUSH    = 2'd2,
        S_AMO_WAIT = 2'd3
    } state_e;

    state_e                     state_q, state_d;
    logic [2:0]                 fence_kind_q, fence_kind_d;
    logic [CNT_WIDTH-1:0]       instret_q;
    logic [15:0]                wdog_q, wdog_d;
    logic                       stall_q, stall_d;
    logic [NR_COMMIT_PORTS-1:0] ack, we_gpr, we_fpr;
    logic [2:0]                 ack_cnt;
    logic [2:0]                 kind0;
    logic                       c0;
    logic                       younger_ok;

    assign kind0      = instr_if.instr_kind_i[0];
    assign c0         = instr_if.instr_valid_i[0] && !instr_if.instr_ex_i[0] && !halt_i;
    // Younger ports may only ride along behind an ordinary port-0 instruction.
    assign younger_ok = !(kind0 inside {K_CSR, K_FENCE, K_FENCE_I, K_SFENCE, K_AMO})
                        && !single_step_i && !halt_i;

    always_comb begin
        state_d            = state_q;
        fence_kind_d       = fence_kind_q;
        ack                = '0;
        we_gpr             = '0;
        we_fpr             = '0;
        commit_lsu_o       = 1'b0;
        commit_csr_o       = 1'b0;
        fence_o            = 1'b0;
        fence_i_o          = 1'b0;
        sfence_vma_o       = 1'b0;
        amo_valid_commit_o = 1'b0;
        flush_commit_o     = 1'b0;
        csr_write_fflags_o = 1'b0;
        fflags_o           = '0;
        exception_valid_o  = 1'b0;

        case (state_q)
            S_IDLE: begin
                exception_valid_o = instr_if.instr_valid_i[0] && !halt_i &&
                                    (instr_if.instr_ex_i[0] || (kind0 == K_CSR && csr_exception_i));
                if (c0) begin
                    case (kind0)
                        K_SIMPLE, K_FPU: ack[0] = 1'b1;
                        K_STORE: if (commit_lsu_ready_i) begin
                            ack[0]       = 1'b1;
                            commit_lsu_o = 1'b1;
                        end
                        K_CSR: if (!csr_exception_i) begin
                            ack[0]       = 1'b1;
                            commit_csr_o = 1'b1;
                        end
                        K_FENCE, K_FENCE_I, K_SFENCE: begin
                            state_d      = S_DRAIN;
                            fence_kind_d = kind0;
                        end
                        default: state_d = S_AMO_WAIT;
                    endcase
                end
                for (int i = 1; i < NR_COMMIT_PORTS; i++) begin
                    if (ack[i-1] && younger_ok && instr_if.instr_valid_i[i] && !instr_if.instr_ex_i[i] &&
                        (instr_if.instr_kind_i[i] == K_SIMPLE || instr_if.instr_kind_i[i] == K_FPU))
                        ack[i] = 1'b1;
                end
                we_gpr = ack & ~instr_if.instr_rd_fpr_i;
                we_fpr = ack & instr_if.instr_rd_fpr_i;
                for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
                    if (ack[i] && instr_if.instr_kind_i[i] == K_FPU) begin
                        csr_write_fflags_o = 1'b1;
                        fflags_o           = fflags_o | instr_if.instr_fflags_i[i];
                    end
                end
            end
            S_DRAIN: begin
                if (halt_i)               state_d = S_IDLE;
                else if (no_st_pending_i) state_d = S_FLUSH;
            end
            S_FLUSH: begin
                fence_o      = (fence_kind_q == K_FENCE);
                fence_i_o    = (fence_kind_q == K_FENCE_I);
                sfence_vma_o = (fence_kind_q == K_SFENCE);
                if (flush_ack_i) begin
                    ack[0]    = 1'b1;
                    we_gpr[0] = !instr_if.instr_rd_fpr_i[0];
                    we_fpr[0] = instr_if.instr_rd_fpr_i[0];
                    state_d   = S_IDLE;
                end
            end
            default: begin
                amo_valid_commit_o = 1'b1;
                if (amo_ack_i) begin
                    ack[0]         = 1'b1;
                    we_gpr[0]      = 1'b1;
                    flush_commit_o = 1'b1;
                    state_d        = S_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        ack_cnt = '0;
        for (int i = 0; i < NR_COMMIT_PORTS; i++) ack_cnt = ack_cnt + 3'(ack[i]);
        if (instr_if.instr_valid_i[0] && !ack[0])
            wdog_d = (wdog_q >= WDOG_MAX) ? WDOG_MAX : wdog_q + 16'd1;
        else
            wdog_d = '0;
        stall_d = stall_q || (wdog_d == WDOG_MAX);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            fence_kind_q <= K_SIMPLE;
            instret_q    <= '0;
            wdog_q       <= '0;
            stall_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            fence_kind_q <= fence_kind_d;
            if (!instret_inhibit_i) instret_q <= instret_q + CNT_WIDTH'(ack_cnt);
            wdog_q       <= wdog_d;
            stall_q      <= stall_d;
        end
    end

    assign instr_if.commit_ack_o = ack;
    assign instr_if.we_gpr_o     = we_gpr;
    assign instr_if.we_fpr_o     = we_fpr;
    assign instret_o             = instret_q;
    assign stall_timeout_o       = stall_q;
    assign state_o               = state_q;

endmodule

// File: tb/tb_commit_stage_mp.sv
// Bench for commit_stage_mp: directed scenarios plus random traffic, every cycle checked
// against a transaction-level model through an expected-value queue.
module tb_commit_stage_mp;
    localparam int N  = 2;
    localparam int CW = 8;
    localparam int WL = 4;
    localparam int W  = 32;

    localparam logic [2:0] SIMPLE = 3'd0, STORE = 3'd1, CSR = 3'd2, FENCE = 3'd3;
    localparam logic [2:0] FENCE_I = 3'd4, SFENCE = 3'd5, AMO = 3'd6, FPU = 3'd7;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_i, halt_i, single_step_i, commit_lsu_ready_i, no_st_pending_i;
    logic          flush_ack_i, amo_ack_i, csr_exception_i, instret_inhibit_i;
    logic          commit_lsu_o, commit_csr_o, fence_o, fence_i_o, sfence_vma_o;
    logic          amo_valid_commit_o, flush_commit_o, csr_write_fflags_o, exception_valid_o;
    logic [4:0]    fflags_o;
    logic [CW-1:0] instret_o;
    logic          stall_timeout_o;
    logic [1:0]    state_o;

    commit_stage_mp_if #(.N(N)) bus ();

    commit_stage_mp #(.NR_COMMIT_PORTS(N), .CNT_WIDTH(CW), .WDOG_LIMIT(WL)) dut (
        .clk_i(clk), .rst_i(rst_i), .instr_if(bus),
        .halt_i(halt_i), .single_step_i(single_step_i),
        .commit_lsu_ready_i(commit_lsu_ready_i), .no_st_pending_i(no_st_pending_i),
        .flush_ack_i(flush_ack_i), .amo_ack_i(amo_ack_i),
        .csr_exception_i(csr_exception_i), .instret_inhibit_i(instret_inhibit_i),
        .commit_lsu_o(commit_lsu_o), .commit_csr_o(commit_csr_o),
        .fence_o(fence_o), .fence_i_o(fence_i_o), .sfence_vma_o(sfence_vma_o),
        .amo_valid_commit_o(amo_valid_commit_o), .flush_commit_o(flush_commit_o),
        .csr_write_fflags_o(csr_write_fflags_o), .fflags_o(fflags_o),
        .exception_valid_o(exception_valid_o), .instret_o(instret_o),
        .stall_timeout_o(stall_timeout_o), .state_o(state_o)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [W-1:0] act_vec;
    assign act_vec = {3'b0, bus.commit_ack_o, bus.we_gpr_o, bus.we_fpr_o, commit_lsu_o, commit_csr_o,
                      fence_o, fence_i_o, sfence_vma_o, amo_valid_commit_o, flush_commit_o,
                      csr_write_fflags_o, fflags_o, exception_valid_o, instret_o, stall_timeout_o};

    // scoreboard monitor
    always @(negedge clk) begin
        if (exp_q.size() > 0) chk("scoreboard", act_vec, exp_q.pop_front());
    end

    // reference model: in-flight port-0 operation plus architectural counters
    int          m_pend = -1;
    bit          m_drained = 1'b0;
    int unsigned m_instret = 0;
    int          m_run = 0;
    bit          m_sticky = 1'b0;

    task automatic model_reset();
        m_pend = -1; m_drained = 1'b0; m_instret = 0; m_run = 0; m_sticky = 1'b0;
    endtask

    task automatic issue();
        logic [1:0] a = '0, wg = '0, wf = '0;
        logic lsu = 0, csr = 0, fe = 0, fi = 0, sf = 0, amo = 0, fc = 0, wff = 0, exc = 0;
        logic [4:0] ff = '0;
        logic [2:0] k0, k1;
        int np;
        bit nd;
        k0 = bus.instr_kind_i[0];
        k1 = bus.instr_kind_i[1];
        np = m_pend;
        nd = m_drained;
        if (m_pend < 0) begin
            exc = bus.instr_valid_i[0] && !halt_i && (bus.instr_ex_i[0] || (k0 == CSR && csr_exception_i));
            if (bus.instr_valid_i[0] && !bus.instr_ex_i[0] && !halt_i) begin
                if (k0 == SIMPLE || k0 == FPU) a[0] = 1;
                else if (k0 == STORE && commit_lsu_ready_i) begin a[0] = 1; lsu = 1; end
                else if (k0 == CSR && !csr_exception_i) begin a[0] = 1; csr = 1; end
                else if (k0 == FENCE || k0 == FENCE_I || k0 == SFENCE) begin np = k0; nd = 0; end
                else if (k0 == AMO) np = AMO;
            end
            if (a[0] && bus.instr_valid_i[1] && !bus.instr_ex_i[1] && (k1 == SIMPLE || k1 == FPU) &&
                !(k0 >= CSR && k0 <= AMO) && !single_step_i && !halt_i)
                a[1] = 1;
            wg = a & ~bus.instr_rd_fpr_i;
            wf = a & bus.instr_rd_fpr_i;
            for (int p = 0; p < N; p++)
                if (a[p] && bus.instr_kind_i[p] == FPU) begin wff = 1; ff = ff | bus.instr_fflags_i[p]; end
        end else if (m_pend == AMO) begin
            amo = 1;
            if (amo_ack_i) begin a[0] = 1; wg[0] = 1; fc = 1; np = -1; end
        end else if (!m_drained) begin
            if (halt_i) np = -1;
            else if (no_st_pending_i) nd = 1;
        end else begin
            fe = (m_pend == FENCE); fi = (m_pend == FENCE_I); sf = (m_pend == SFENCE);
            if (flush_ack_i) begin
                a[0] = 1; wg[0] = !bus.instr_rd_fpr_i[0]; wf[0] = bus.instr_rd_fpr_i[0]; np = -1;
            end
        end
        exp_q.push_back({3'b0, a, wg, wf, lsu, csr, fe, fi, sf, amo, fc, wff, ff, exc,
                         m_instret[CW-1:0], m_sticky});
        if (rst_i) model_reset();
        else begin
            m_pend = np;
            m_drained = nd;
            if (!instret_inhibit_i) m_instret = (m_instret + $countones(a)) % (1 << CW);
            if (bus.instr_valid_i[0] && !a[0]) m_run = (m_run < WL) ? m_run + 1 : WL;
            else m_run = 0;
            if (m_run == WL) m_sticky = 1'b1;
        end
        @(negedge clk);
        #1;
    endtask

    // driver tasks
    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        issue();
        advance();
    endtask

    task automatic clr();
        bus.instr_valid_i = '0; bus.instr_ex_i = '0; bus.instr_kind_i = '0;
        bus.instr_fflags_i = '0; bus.instr_rd_fpr_i = '0;
        halt_i = 0; single_step_i = 0; commit_lsu_ready_i = 0; no_st_pending_i = 0;
        flush_ack_i = 0; amo_ack_i = 0; csr_exception_i = 0; instret_inhibit_i = 0;
    endtask

    task automatic put(input int p, input logic [2:0] k, input logic [4:0] f = 5'h0, input logic r = 1'b0);
        bus.instr_valid_i[p] = 1'b1; bus.instr_ex_i[p] = 1'b0; bus.instr_kind_i[p] = k;
        bus.instr_fflags_i[p] = f; bus.instr_rd_fpr_i[p] = r;
    endtask

    task automatic do_reset();
        clr();
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
    endtask

    int hi_a, hi_b, hi_c;

    initial begin
        clr();
        rst_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst_i = 1'b0;
        chk("reset_state", 32'(state_o), 32'd0);
        chk("reset_instret", 32'(instret_o), 32'd0);

        // two simple commits, then single-step
        do_reset();
        put(0, SIMPLE); put(1, SIMPLE);
        issue(); chk("dual_ack", 32'(bus.commit_ack_o), 32'h3); advance();
        single_step_i = 1;
        issue(); chk("step_ack", 32'(bus.commit_ack_o), 32'h1); chk("instret_plus2", 32'(instret_o), 32'd2); advance();
        clr();
        issue(); chk("instret_plus1", 32'(instret_o), 32'd3); advance();

        // FPU flag accumulation
        put(0, FPU, 5'h01, 1'b1); put(1, FPU, 5'h04, 1'b1);
        issue(); chk("fflags_we", 32'(csr_write_fflags_o), 32'd1); chk("fflags_val", 32'(fflags_o), 32'h05);
        chk("fpr_we", 32'(bus.we_fpr_o), 32'h3); advance();
        clr();

        // fence with delayed drain and flush ack
        do_reset();
        put(0, FENCE); put(1, SIMPLE);
        hi_a = 0; hi_b = 0;
        for (int c = 0; c < 6; c++) begin
            no_st_pending_i = (c >= 3);
            flush_ack_i = (c == 5);
            issue();
            if (fence_o) hi_a++;
            if (bus.commit_ack_o[1]) hi_b++;
            chk("fence_ack", 32'(bus.commit_ack_o), (c == 5) ? 32'h1 : 32'h0);
            advance();
        end
        chk("fence_high_cycles", 32'(hi_a), 32'd2);
        chk("fence_port1_never", 32'(hi_b), 32'd0);
        clr();

        // AMO acknowledged on the fourth wait cycle
        do_reset();
        put(0, AMO);
        hi_a = 0; hi_c = 0;
        for (int c = 0; c < 5; c++) begin
            amo_ack_i = (c == 4);
            issue();
            if (amo_valid_commit_o) hi_a++;
            if (flush_commit_o) hi_c++;
            if (c == 4) begin
                chk("amo_ack", 32'(bus.commit_ack_o), 32'h1);
                chk("amo_we_gpr", 32'(bus.we_gpr_o), 32'h1);
            end
            advance();
        end
        chk("amo_valid_cycles", 32'(hi_a), 32'd4);
        chk("amo_flush_cycles", 32'(hi_c), 32'd1);
        clr();

        // watchdog on a stalled store
        do_reset();
        put(0, STORE);
        for (int c = 0; c < 6; c++) begin
            commit_lsu_ready_i = (c == 5);
            issue();
            chk("wdog_flag", 32'(stall_timeout_o), (c < 4) ? 32'd0 : 32'd1);
            if (c == 5) chk("store_commit", 32'(commit_lsu_o), 32'd1);
            advance();
        end
        clr();
        issue(); chk("wdog_sticky", 32'(stall_timeout_o), 32'd1); advance();

        // reset while in FLUSH
        do_reset();
        put(0, SIMPLE); put(1, SIMPLE);
        cyc();
        clr();
        put(0, FENCE); no_st_pending_i = 1;
        cyc();
        cyc();
        rst_i = 1;
        issue(); chk("flush_fence_on", 32'(fence_o), 32'd1); chk("flush_instret", 32'(instret_o), 32'd2); advance();
        rst_i = 0;
        clr();
        issue();
        chk("rst_fence_off", 32'(fence_o), 32'd0);
        chk("rst_instret", 32'(instret_o), 32'd0);
        chk("rst_state", 32'(state_o), 32'd0);
        advance();

        // counter wrap: 280 retirements modulo 256
        do_reset();
        put(0, SIMPLE); put(1, SIMPLE);
        repeat (140) cyc();
        clr();
        issue(); chk("instret_wrap", 32'(instret_o), 32'd24); advance();

        // random traffic
        for (int t = 0; t < 1500; t++) begin
            for (int p = 0; p < N; p++) begin
                bus.instr_valid_i[p]  = ($urandom_range(0, 9) < 8);
                bus.instr_ex_i[p]     = ($urandom_range(0, 9) == 0);
                bus.instr_kind_i[p]   = 3'($urandom_range(0, 7));
                bus.instr_fflags_i[p] = 5'($urandom);
                bus.instr_rd_fpr_i[p] = 1'($urandom_range(0, 1));
            end
            halt_i             = ($urandom_range(0, 9) == 0);
            single_step_i      = ($urandom_range(0, 6) == 0);
            commit_lsu_ready_i = 1'($urandom_range(0, 1));
            no_st_pending_i    = 1'($urandom_range(0, 1));
            flush_ack_i        = ($urandom_range(0, 2) == 0);
            amo_ack_i          = ($urandom_range(0, 2) == 0);
            csr_exception_i    = ($urandom_range(0, 4) == 0);
            instret_inhibit_i  = ($urandom_range(0, 9) == 0);
            rst_i              = ($urandom_range(0, 199) == 0);
            cyc();
        end
        rst_i = 0;
        clr();

        // final report
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
